// File: rtl/det3_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : det3_seq_ctrl
// Description : Sequential 3x3 signed determinant engine. One start request
//               captures the matrix; the result is built from the six Leibniz
//               terms over 12 cycles on a single shared signed multiplier.
//               The outputs are the low 8 bits of the exact determinant and an
//               overflow flag.
// Ports       : clk   - system clock, rising edge
//               rst   - asynchronous active-high reset
//               start - compute request, sampled only while idle
//               m     - 3x3 matrix, signed 8-bit entries, a00 in m[71:64]
//               busy  - high while the computation is in CALC or FIN
//               done  - one-cycle pulse marking that det/ovf are valid
//               det   - low 8 bits of the exact determinant
//               ovf   - exact determinant lies outside [-128,127]
// Revision    : 1.0 - initial release
// ============================================================================
module det3_seq_ctrl #(
    parameter int ACC_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [71:0] m,
    output logic        busy,
    output logic        done,
    output logic [7:0]  det,
    output logic        ovf
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIN  = 2'd2;

    localparam logic [3:0] c_LAST_STEP = 4'd11;

    localparam logic signed [ACC_W-1:0] c_DET_MAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] c_DET_MIN = -ACC_W'(128);

    logic [1:0]               r_state;
    logic [1:0]               w_next_state;
    logic [71:0]              r_mat;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [15:0]       r_part;
    logic [3:0]               r_step;
    logic                     r_done;
    logic [7:0]               r_det;
    logic                     r_ovf;

    logic signed [7:0]        w_e [9];
    logic signed [7:0]        w_f0;
    logic signed [7:0]        w_f1;
    logic signed [7:0]        w_f2;
    logic signed [23:0]       w_mul_a;
    logic signed [23:0]       w_mul_b;
    logic signed [23:0]       w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic                     w_sub;

    // Unpack the captured matrix, index = 3*row + col.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            w_e[i] = r_mat[71 - 8*i -: 8];
        end
    end

    // Factor selection for term t = step/2.
    always_comb begin
        w_f0 = '0;
        w_f1 = '0;
        w_f2 = '0;
        case (r_step[3:1])
            3'd0: begin w_f0 = w_e[0]; w_f1 = w_e[4]; w_f2 = w_e[8]; end
            3'd1: begin w_f0 = w_e[1]; w_f1 = w_e[5]; w_f2 = w_e[6]; end
            3'd2: begin w_f0 = w_e[2]; w_f1 = w_e[3]; w_f2 = w_e[7]; end
            3'd3: begin w_f0 = w_e[2]; w_f1 = w_e[4]; w_f2 = w_e[6]; end
            3'd4: begin w_f0 = w_e[0]; w_f1 = w_e[5]; w_f2 = w_e[7]; end
            3'd5: begin w_f0 = w_e[1]; w_f1 = w_e[3]; w_f2 = w_e[8]; end
            default: ;
        endcase
    end

    // The single shared multiplier: even steps form f0*f1, odd steps form
    // partial*f2. Operands are sign-extended to 24 bits; the low 24 bits of
    // the product are exact since |partial*f2| < 2^23.
    always_comb begin
        if (r_step[0]) begin
            w_mul_a = {{8{r_part[15]}}, r_part};
            w_mul_b = {{16{w_f2[7]}}, w_f2};
        end else begin
            w_mul_a = {{16{w_f0[7]}}, w_f0};
            w_mul_b = {{16{w_f1[7]}}, w_f1};
        end
        w_prod     = w_mul_a * w_mul_b;
        w_prod_ext = {{(ACC_W-24){w_prod[23]}}, w_prod};
        w_sub      = (r_step[3:1] >= 3'd3);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next_state = c_CALC;
            c_CALC:  if (r_step == c_LAST_STEP) w_next_state = c_FIN;
            c_FIN:   w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        busy = (r_state == c_CALC) || (r_state == c_FIN);
        done = r_done;
        det  = r_det;
        ovf  = r_ovf;
    end

    // Datapath: capture, partial product, accumulation and result latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mat  <= '0;
            r_acc  <= '0;
            r_part <= '0;
            r_step <= '0;
            r_done <= 1'b0;
            r_det  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_mat  <= m;
                        r_acc  <= '0;
                        r_step <= '0;
                    end
                end
                c_CALC: begin
                    if (r_step[0]) begin
                        r_acc <= w_sub ? (r_acc - w_prod_ext) : (r_acc + w_prod_ext);
                    end else begin
                        r_part <= w_prod[15:0];
                    end
                    r_step <= r_step + 4'd1;
                end
                c_FIN: begin
                    r_det  <= r_acc[7:0];
                    r_ovf  <= (r_acc > c_DET_MAX) || (r_acc < c_DET_MIN);
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/det3_seq_ctrl.md
DET3_SEQ_CTRL -- requirements
Module: det3_seq_ctrl

Interface
REQ-001 Parameter ACC_W, default 32: accumulator width in bits; legal values are 26 or greater.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to compute one determinant; sampled only in IDLE.
REQ-005 m  input  72  3x3 matrix of signed 8-bit entries, mapped as follows:
- a00=m[71:64], a01=[63:56], a02=[55:48]
- a10=[47:40], a11=[39:32], a12=[31:24]
- a20=[23:16], a21=[15:8], a22=[7:0]
REQ-006 busy  output  1  high while a computation is in progress.
REQ-007 done  output  1  one-cycle pulse marking that det/ovf are valid.
REQ-008 det  output  8  signed determinant, low 8 bits of the exact result.
REQ-009 ovf  output  1  high when the exact determinant lies outside [-128,127].

Function
REQ-010 All matrix entries shall be treated as two's-complement signed; all products and accumulation shall be signed.
REQ-011 The block shall use exactly one shared signed multiplier, with one multiply issued per cycle; no parallel product trees.
REQ-012 The FSM shall have states IDLE, CALC and FIN.
REQ-013 Transitions: IDLE->CALC on start=1; CALC->FIN after step 11; FIN->IDLE unconditionally.
REQ-014 On the edge that samples start=1 in IDLE:
- m is captured into an internal register;
- the accumulator is cleared;
- the step counter is set to 0.
REQ-015 Changes on m after capture shall not affect the current result.
REQ-016 CALC shall run steps 0..11 on 12 consecutive edges. Term t=step/2, with the following order:
- t0 = +a00*a11*a22
- t1 = +a01*a12*a20
- t2 = +a02*a10*a21
- t3 = -a02*a11*a20
- t4 = -a00*a12*a21
- t5 = -a01*a10*a22
REQ-017 On an even step, the first two factors of term t shall be multiplied into a 16-bit signed partial register.
REQ-018 On an odd step, the partial shall be multiplied by the third factor to give a 24-bit signed value, sign-extended to ACC_W, and added to the accumulator for t0..t2 or subtracted for t3..t5.
REQ-019 On the FIN edge:
- det = acc[7:0];
- ovf = (acc > 127) or (acc < -128), evaluated as signed;
- done = 1.
REQ-020 done shall be cleared on the following edge.
REQ-021 det and ovf shall hold their values until the next FIN or reset.
REQ-022 Latency: with start sampled at edge E0, done is high for exactly the cycle following edge E13.
REQ-023 busy = 1 exactly when the state is CALC or FIN, i.e. after E0 through E12.
REQ-024 busy is low while done is high.
REQ-025 start shall be ignored in CALC and FIN; no queuing, and no effect on the captured matrix.
REQ-026 start held high continuously shall launch back-to-back computations, each beginning on the first IDLE edge after done.
REQ-027 The accumulator shall never wrap: the maximum |sum| is 6*2^21, which is below 2^(ACC_W-1).

Reset
REQ-028 When rst=1, regardless of clk, the following shall be asynchronously set:
- state = IDLE;
- busy = 0, done = 0;
- det = 8'h00, ovf = 0;
- accumulator = 0, partial = 0, step = 0;
- captured matrix = 0.
REQ-029 Reset during CALC or FIN shall abort the computation; no done pulse shall follow.
REQ-030 After rst is released, the first start is accepted on the next edge.

Verification
REQ-031 Identity matrix with a 1-cycle start pulse -> done exactly 14 edges later, det=8'h01, ovf=0, busy high for 13 cycles.
REQ-032 diag(2,3,4), zeros elsewhere -> det=8'h18, ovf=0; the same matrix with a00=-2 -> det=8'hE8 (-24), ovf=0.
REQ-033 diag(8,8,8) -> det=8'h00, ovf=1; all entries 8'h80 (-128, singular) -> det=8'h00, ovf=0.
REQ-034 Rows (1,2,3),(4,5,6),(7,8,10) -> det=8'hFD (-3), ovf=0.
REQ-035 Matrix changed and start pulsed at cycle 5 of CALC -> result corresponds to the original matrix only, exactly one done pulse, no second computation.
REQ-036 rst asserted at cycle 7 of CALC -> det/ovf/busy/done immediately 0 with no done pulse; a new start after release yields the correct result 14 edges later.
